// File: rtl/lut_mux_pkg.sv
// Shared types and helpers for the programmable mux-tree lookup table.
package lut_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Table depth for a given number of select bits.
  function automatic int lut_depth(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/lut_mux_seq_if.sv
// Config and lookup ports of lut_mux_seq. master = traffic source/sink, slave = the LUT.
interface lut_mux_seq_if #(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1
);
  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_done;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_y;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_sel,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_y
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_sel,
    output cfg_ready, cfg_done, in_ready, out_valid, out_y
  );
endinterface

// File: rtl/lut_mux_seq_mux_tree.sv
// mux_tree_n: combinational 2:1 mux tree covering levels LVL_LO..LVL_HI-1 of a
// SEL_W-level tree. Level 0 is the leaf level; sel[0] drives the lowest level
// implemented here. Entry i of din sits at bits [i*DATA_W +: DATA_W].
module mux_tree_n #(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = SEL_W
) (
  input  logic [DATA_W*(1<<(SEL_W-LVL_LO))-1:0] din,
  input  logic [LVL_HI-LVL_LO-1:0]              sel,
  output logic [DATA_W*(1<<(SEL_W-LVL_HI))-1:0] dout
);

  localparam int N_LV = LVL_HI - LVL_LO;
  localparam int N_IN = 1 << (SEL_W - LVL_LO);

  for (genvar k = 0; k <= N_LV; k++) begin : g_lvl
    logic [DATA_W*(N_IN>>k)-1:0] v;
    if (k == 0) begin : g_in
      assign v = din;
    end else begin : g_mux
      for (genvar j = 0; j < (N_IN >> k); j++) begin : g_node
        assign v[j*DATA_W +: DATA_W] = sel[k-1] ? g_lvl[k-1].v[(2*j+1)*DATA_W +: DATA_W]
                                                : g_lvl[k-1].v[(2*j)*DATA_W +: DATA_W];
      end
    end
  end

  assign dout = g_lvl[N_LV].v;

endmodule

// File: rtl/lut_mux_seq.sv
// lut_mux_seq: run-time loadable 2^SEL_W-entry lookup table with registered result.
// Optional build macro LUT_MUX_PIPE_EN adds a pipeline register after the lower
// SEL_W/2 mux levels (2-cycle lookup latency); without it latency is 1 cycle.
//
// state | meaning
// EMPTY | after reset, table zero, no lookups accepted
// LOAD  | accepting table beats in index order 0..DEPTH-1
// RUN   | table valid, accepting lookups at one per cycle
module lut_mux_seq
  import lut_mux_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1
) (
  input logic         clk,
  input logic         rst,
  lut_mux_seq_if.slave bus
);

  localparam int DEPTH = lut_depth(SEL_W);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cnt;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DEPTH*DATA_W-1:0] tbl_flat;
  logic              cfg_ready, in_ready, cfg_done;
  logic              beat_acc, look_acc, pipe_busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_y, y;

  // cfg_start always wins over a coincident beat, so a restart never writes stale data.
  assign beat_acc = cfg_ready && bus.cfg_valid && !bus.cfg_start;
  assign look_acc = in_ready && bus.in_valid;

  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = in_ready;
  assign bus.cfg_done  = cfg_done;
  assign bus.out_valid = out_valid;
  assign bus.out_y     = out_y;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state and handshake readiness.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    case (state)
      EMPTY: begin
        if (bus.cfg_start) state_nxt = LOAD;
      end
      LOAD: begin
        cfg_ready = !pipe_busy;
        if (!bus.cfg_start && bus.cfg_valid && !pipe_busy && cnt == LAST_IDX)
          state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (bus.cfg_start) state_nxt = LOAD;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Table storage, load counter and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cfg_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      cfg_done <= beat_acc && (cnt == LAST_IDX);
      if (bus.cfg_start) begin
        cnt <= '0;
      end else if (beat_acc) begin
        tbl[cnt] <= bus.cfg_data;
        cnt      <= cnt + 1'b1;
      end
    end
  end

  // Flatten the table for the mux tree, entry i at slice i.
  always_comb begin
    tbl_flat = '0;
    for (int i = 0; i < DEPTH; i++) tbl_flat[i*DATA_W +: DATA_W] = tbl[i];
  end

`ifdef LUT_MUX_PIPE_EN
  localparam int P_LV  = SEL_W / 2;
  localparam int MID_N = 1 << (SEL_W - P_LV);

  logic [MID_N*DATA_W-1:0] mid, mid_q;
  logic [SEL_W-P_LV-1:0]   sel_hi_q;
  logic                    mid_vld;

  if (P_LV > 0) begin : g_lo
    mux_tree_n #(.SEL_W(SEL_W), .DATA_W(DATA_W), .LVL_LO(0), .LVL_HI(P_LV)) u_tree_lo (
      .din  (tbl_flat),
      .sel  (bus.in_sel[P_LV-1:0]),
      .dout (mid)
    );
  end else begin : g_nolo
    assign mid = tbl_flat;
  end

  mux_tree_n #(.SEL_W(SEL_W), .DATA_W(DATA_W), .LVL_LO(P_LV), .LVL_HI(SEL_W)) u_tree_hi (
    .din  (mid_q),
    .sel  (sel_hi_q),
    .dout (y)
  );

  // A lookup sitting in the mid register holds off table writes until it drains.
  assign pipe_busy = mid_vld;

  // Two-stage lookup pipeline: partial mux result, then final registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_q     <= '0;
      sel_hi_q  <= '0;
      mid_vld   <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      mid_vld   <= look_acc;
      out_valid <= mid_vld;
      if (look_acc) begin
        mid_q    <= mid;
        sel_hi_q <= bus.in_sel[SEL_W-1:P_LV];
      end
      if (mid_vld) out_y <= y;
    end
  end
`else
  mux_tree_n #(.SEL_W(SEL_W), .DATA_W(DATA_W), .LVL_LO(0), .LVL_HI(SEL_W)) u_tree (
    .din  (tbl_flat),
    .sel  (bus.in_sel),
    .dout (y)
  );

  assign pipe_busy = 1'b0;

  // Single-cycle registered lookup result; out_y holds between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      out_valid <= look_acc;
      if (look_acc) out_y <= y;
    end
  end
`endif

endmodule

// File: doc/lut_mux_seq.md
Name: lut_mux_seq

Overview:
- Programmable 2^SEL_W-entry lookup table built as a parametric binary mux tree.
- Successor to the fixed 2/4/8-input mux truth-table blocks: the table is loaded serially over a valid/ready config port, and lookups are issued on a valid/ready input port.
- Result is registered.
- Used wherever a run-time reconfigurable N-input boolean or small-word function is needed.

Parameters:
- SEL_W, 3, number of select bits; table depth DEPTH = 2^SEL_W (legal range 1..8).
- DATA_W, 1, width of each table entry and of out_y (legal range 1..32).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; begins a full table (re)load.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  high only in LOAD.
- cfg_data  in  DATA_W  table entry; beats are written in index order 0..DEPTH-1.
- cfg_done  out  1  one-cycle pulse when the last entry is written.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  high only in RUN.
- in_sel  in  SEL_W  table index (MSB = top mux stage select).
- out_valid  out  1  result valid, one cycle per accepted request.
- out_y  out  DATA_W  table[in_sel] for the accepted request.

Behaviour:
- States: EMPTY, LOAD, RUN.
- Reset value: EMPTY. Table is cleared to all zeros, load counter = 0, and cfg_ready, cfg_done, in_ready, out_valid and out_y are all 0.
- EMPTY:
  - cfg_start -> LOAD.
  - in_ready = 0; lookups are not accepted.
- LOAD:
  - cfg_ready = 1.
  - Beat accepted when cfg_valid && cfg_ready: table[cnt] <= cfg_data, cnt <= cnt+1.
  - When the beat with cnt == DEPTH-1 is accepted: cnt wraps to 0, state -> RUN, and cfg_done pulses in the same edge's following cycle.
  - Gaps in cfg_valid are allowed; cnt holds through them.
  - cfg_start in LOAD restarts the load: cnt <= 0. A beat presented in the same cycle is discarded. Entries already written keep their values until overwritten.
- RUN:
  - in_ready = 1.
  - Lookup accepted when in_valid && in_ready.
  - Next cycle: out_valid = 1 and out_y = table[in_sel sampled].
  - With no accepted request, out_valid = 0 and out_y holds its last value.
  - No output backpressure; the sink must accept every out_valid cycle.
  - Back-to-back requests give back-to-back results, throughput 1/cycle.
- cfg_start in RUN:
  - State -> LOAD at the next edge.
  - A lookup accepted in that same cycle completes normally using the old table.
  - in_ready is 0 from the next cycle on.
- cfg_start in EMPTY/RUN coincident with cfg_valid: the beat is not accepted, because cfg_ready is still 0.
- Table writes and lookups are mutually exclusive by state, so there is no read/write hazard.
- Async rst mid-LOAD or mid-RUN: immediate return to EMPTY, table zeroed, any pending out_valid dropped.
- The mux tree is SEL_W levels of 2:1 muxes. Level k uses in_sel[k], with LSB at the leaf level, matching the legacy M2/M4/M8 ordering.

Optional Feature:
- Macro: LUT_MUX_PIPE_EN.
- Defined: a pipeline register is inserted after level floor(SEL_W/2) of the mux tree.
  - Lookup latency becomes 2 cycles; throughput remains 1/cycle.
  - out_valid is delayed accordingly.
  - A lookup in flight when cfg_start arrives still completes with the old table. LOAD keeps cfg_ready = 0 until the pipe is empty.
- Undefined: single-cycle latency as above, and cfg_ready rises the cycle after entering LOAD.

Decomposition:
- Package lut_mux_pkg: state enum (EMPTY=2'd0, LOAD=2'd1, RUN=2'd2) and the function computing DEPTH from SEL_W.
- Sub-module mux_tree_n (parametric SEL_W/DATA_W combinational 2:1 mux tree) is natural. It is instantiated once and, with LUT_MUX_PIPE_EN, split into two halves around the pipeline register.

Test Plan:
- Reset then lookup attempt: in_valid=1, in_sel=3 in EMPTY -> in_ready=0, out_valid stays 0.
- Load parity table (SEL_W=3, DATA_W=1), beats 0,1,1,0,1,0,0,1 with cfg_valid gaps of 0–2 cycles:
  - cfg_done pulses once after the 8th beat.
  - Sweep sel=0..7 back-to-back -> out_y = 0,1,1,0,1,0,0,1, out_valid high for 8 consecutive cycles.
- Reload in RUN: cfg_start with in_sel=5 in the same cycle -> out_y=0 (old table).
  - Then load the majority table 0,0,0,1,0,1,1,1; sel=5 -> 1 and sel=4 -> 0.
- Restart mid-load: after 4 beats pulse cfg_start, then send 8 beats of all-ones -> all lookups return 1 and cfg_done fires exactly once.
- Async rst asserted between clock edges during LOAD beat 5 -> outputs 0 immediately; after reload the entries not rewritten read 0.
- DATA_W=8, SEL_W=2, table 8'hA5, 8'h3C, 8'hFF, 8'h00; with LUT_MUX_PIPE_EN defined -> sel=1 gives 8'h3C two cycles after acceptance. Without the macro, one cycle after.
